// File: rtl/eth_rx_uart_bridge.sv
// eth_rx_uart_bridge: drains a received frame from the RX buffer RAM
// and streams it out as UART 8N1, high byte of each word first.
module eth_rx_uart_bridge #(
    parameter int CLK_FREQ       = 100,
    parameter int BAUD           = 115200,
    parameter int BUF_ADDR_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_done,
    input  logic [BUF_ADDR_WIDTH:0]   rx_len,
    output logic [BUF_ADDR_WIDTH-1:0] buf_rdaddress,
    input  logic [15:0]               buf_q,
    output logic                      uart_txd,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int W   = BUF_ADDR_WIDTH;
    localparam int DIV = (CLK_FREQ * 1_000_000 + BAUD / 2) / BAUD;
    localparam int DW  = $clog2(DIV + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [W:0]    MAX_LEN  = {1'b1, {W{1'b0}}};
    localparam logic [W:0]    ONE      = (W+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        SHIFT
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] div_cnt;
    logic [3:0]    bit_idx;
    logic          lo_byte;
    logic [W:0]    rem;
    logic [15:0]   word_q;
    logic [15:0]   hold_q;
    logic [7:0]    sh;
    logic [1:0]    pf;

    logic accept;
    logic drop;
    logic bit_end;
    logic byte_end;
    logic last_end;

    assign busy     = (state != IDLE);
    assign accept   = rx_done && (state == IDLE) && !done && (rx_len != '0);
    assign drop     = rx_done && ((state != IDLE) || done);
    assign bit_end  = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign byte_end = bit_end && (bit_idx == 4'd9);
    assign last_end = byte_end && lo_byte && (rem == ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = SHIFT;
            SHIFT:   if (last_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_rdaddress <= '0;
            uart_txd      <= 1'b1;
            done          <= 1'b0;
            overrun       <= 1'b0;
            div_cnt       <= '0;
            bit_idx       <= '0;
            lo_byte       <= 1'b0;
            rem           <= '0;
            word_q        <= '0;
            hold_q        <= '0;
            sh            <= '0;
            pf            <= '0;
        end else begin
            done <= last_end;
            pf   <= {pf[0], 1'b0};
            // next word lands two edges after its address was issued
            if (pf[1]) hold_q <= buf_q;
            if (drop) overrun <= 1'b1;
            if (accept) begin
                overrun       <= 1'b0;
                buf_rdaddress <= '0;
                rem           <= (rx_len > MAX_LEN) ? MAX_LEN : rx_len;
            end
            if (state == WAIT) begin
                word_q   <= buf_q;
                sh       <= buf_q[15:8];
                uart_txd <= 1'b0;
                bit_idx  <= '0;
                div_cnt  <= '0;
                lo_byte  <= 1'b0;
            end
            if (state == SHIFT) begin
                if (!bit_end) begin
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    div_cnt <= '0;
                    if (bit_idx < 4'd8) begin
                        uart_txd <= sh[0];
                        sh       <= {1'b0, sh[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                    end else if (bit_idx == 4'd8) begin
                        uart_txd <= 1'b1;
                        bit_idx  <= 4'd9;
                    end else if (!lo_byte) begin
                        sh       <= word_q[7:0];
                        uart_txd <= 1'b0;
                        bit_idx  <= '0;
                        lo_byte  <= 1'b1;
                        if (rem > ONE) begin
                            buf_rdaddress <= buf_rdaddress + 1'b1;
                            pf[0]         <= 1'b1;
                        end
                    end else if (!last_end) begin
                        word_q   <= hold_q;
                        sh       <= hold_q[15:8];
                        uart_txd <= 1'b0;
                        bit_idx  <= '0;
                        lo_byte  <= 1'b0;
                        rem      <= rem - ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_uart_bridge.sv
// tb_eth_rx_uart_bridge: directed vectors against a registered-address
// RAM model, DIV=4 (1 MHz clock, 250 kbaud).
module tb_eth_rx_uart_bridge;

    localparam int W   = 9;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_done;
    logic [W:0]   rx_len;
    logic [W-1:0] buf_rdaddress;
    logic [15:0]  buf_q;
    logic         uart_txd;
    logic         busy;
    logic         done;
    logic         overrun;

    logic [15:0]  mem [512];
    logic [W-1:0] ra;

    int nvec = 0;
    int nerr = 0;

    eth_rx_uart_bridge #(
        .CLK_FREQ      (1),
        .BAUD          (250000),
        .BUF_ADDR_WIDTH(W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_done      (rx_done),
        .rx_len       (rx_len),
        .buf_rdaddress(buf_rdaddress),
        .buf_q        (buf_q),
        .uart_txd     (uart_txd),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ra <= buf_rdaddress;
    assign buf_q = mem[ra];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input int idx);
        int w, p;
        logic [15:0] wd;
        logic [7:0] b;
        w  = idx / 20;
        p  = idx % 20;
        wd = mem[w];
        b  = (p < 10) ? wd[15:8] : wd[7:0];
        p  = p % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    task automatic run_frame(input int len, input int nw, input bit chk_bits,
                             input int ov_at, input bit pod);
        int dk, k, lastaddr;
        bit seen;
        dk = 2 + 20 * DIV * nw;
        @(negedge clk);
        rx_done = 1'b1;
        rx_len  = (W+1)'(len);
        @(posedge clk);
        #1 rx_done = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_addr", buf_rdaddress, 0);
        check("acc_ovr", overrun, 0);
        lastaddr = 0;
        seen = 0;
        for (k = 1; k <= dk + 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (int'(buf_rdaddress) != lastaddr) begin
                check("addr_step", buf_rdaddress, lastaddr + 1);
                lastaddr = int'(buf_rdaddress);
            end
            if (done) begin
                seen = 1;
                check("done_at", k, dk);
                check("done_busy", busy, 0);
                if (pod) begin
                    rx_done = 1'b1;
                    rx_len  = 1;
                end
            end else if (chk_bits) begin
                if (k < 2) check("txd_idle", uart_txd, 1);
                else if (k < dk) check("txd", uart_txd, exp_bit((k - 2) / DIV));
            end
            if (ov_at > 0 && k == ov_at) begin
                rx_done = 1'b1;
                rx_len  = 1;
            end else if (ov_at > 0 && k == ov_at + 1) begin
                rx_done = 1'b0;
            end
        end
        if (!seen) check("done_seen", 0, 1);
        check("last_addr", lastaddr, nw - 1);
        @(posedge clk);
        #1 rx_done = 1'b0;
        check("done_pulse", done, 0);
        check("post_busy", busy, 0);
        if (pod) check("ovr_on_done", overrun, 1);
    endtask

    initial begin
        bit sb, st, sd;
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_len  = '0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        mem[0] = 16'h1234;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_txd", uart_txd, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovr", overrun, 0);
        check("rst_addr", buf_rdaddress, 0);

        // single word 0x1234
        run_frame(1, 1, 1, 0, 0);

        // three words streamed back to back
        mem[0] = 16'hA55A;
        mem[1] = 16'h00FF;
        mem[2] = 16'h8001;
        run_frame(3, 3, 1, 0, 0);

        // zero length is ignored
        @(negedge clk);
        rx_done = 1'b1;
        rx_len  = '0;
        @(negedge clk);
        rx_done = 1'b0;
        sb = 0; st = 0; sd = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            sb |= busy;
            st |= !uart_txd;
            sd |= done;
        end
        check("len0_busy", sb, 0);
        check("len0_txd", st, 0);
        check("len0_done", sd, 0);
        check("len0_ovr", overrun, 0);

        // dropped pulse mid-transfer, then on the done cycle
        mem[0] = 16'h1234;
        run_frame(1, 1, 1, 20, 0);
        check("ovr_mid", overrun, 1);
        run_frame(1, 1, 1, 0, 1);

        // asynchronous reset mid-byte
        @(negedge clk);
        rx_done = 1'b1;
        rx_len  = 1;
        @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        check("pre_rst_txd", uart_txd, 0);
        rst_n = 1'b0;
        #1;
        check("arst_txd", uart_txd, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ovr", overrun, 0);
        check("arst_addr", buf_rdaddress, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sd = 0;
        repeat (10) begin
            @(posedge clk);
            #1 sd |= done;
        end
        check("arst_nodone", sd, 0);
        run_frame(1, 1, 1, 0, 0);

        // oversize length clamps to the full buffer
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 3 + 1);
        run_frame(1023, 512, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/eth_rx_uart_bridge.md
# eth_rx_uart_bridge

Drains a received Ethernet payload out of the 16-bit RX buffer RAM and serialises it on the UART transmit line, so received frames can be observed on a host terminal. It sits between the W5300 driver's RX-complete notification and the RX buffer RAM's read port, which is otherwise unused. It performs the read side of the buffer that the driver writes. It also owns `uart_txd`.

## Interface

Parameters:
- `CLK_FREQ`, default 100: clock frequency in MHz.
- `BAUD`, default 115200: UART bit rate.
- `BUF_ADDR_WIDTH`, default 9: RX buffer word-address width (W).

Ports (direction, width, meaning):
- `clk`, in, 1: the single clock for the block.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `rx_done`, in, 1: one-cycle pulse meaning a frame is complete in the RX buffer.
- `rx_len`, in, W+1: frame length in 16-bit words. Sampled on the same cycle as `rx_done`.
- `buf_rdaddress`, out, W: RX buffer read address. Registered output.
- `buf_q`, in, 16: RX buffer read data.
- `uart_txd`, out, 1: UART 8N1 serial output. Idle level is high.
- `busy`, out, 1: high while a frame is being drained.
- `done`, out, 1: one-cycle pulse when the last stop bit has completed.
- `overrun`, out, 1: sticky flag. Set when an `rx_done` pulse was dropped.

## Operation

- Bit period DIV = (CLK_FREQ*1_000_000 + BAUD/2) / BAUD clock cycles, rounded to nearest. At the defaults, DIV = 868.
- Reset values: `uart_txd`=1, `busy`=0, `done`=0, `overrun`=0, `buf_rdaddress`=0. All counters clear, state is IDLE.
- States: IDLE, FETCH, WAIT, SHIFT.
  - IDLE to FETCH: on `rx_done`=1 with `rx_len`≠0. The block latches len = min(`rx_len`, 2^W), sets `busy`, clears `overrun`, and sets `buf_rdaddress`=0.
  - FETCH to WAIT: unconditional, one cycle. This is the RAM address-register cycle.
  - WAIT to SHIFT: the block captures `buf_q` into the word register. It loads the byte shifter with `buf_q[15:8]` and drives the start bit.
  - SHIFT: each byte is sent as start (0), 8 data bits LSB first, then stop (1), each held for DIV cycles.
    - The high byte goes first, then the low byte (network order).
    - After the high byte's stop bit, the low byte's start bit follows on the next cycle with no gap.
- Prefetch: when the low byte's start bit begins and words remain, `buf_rdaddress` increments. The next word is captured two cycles later into a holding register. Consecutive words therefore stream with no idle time between bytes.
- Completion: at the end of the last low byte's stop bit, the block returns to IDLE. `busy` drops and `done` pulses high for exactly one cycle. `buf_rdaddress` holds its last value.
- Input edge cases:
  - `rx_len`=0: the pulse is ignored. `busy` stays 0 and no `done` pulse is produced.
  - `rx_len` > 2^W: clamped to 2^W. Addresses run 0 to 2^W−1 and never wrap.
  - `rx_done` while `busy`=1, including on the `done` cycle: the pulse is dropped and `overrun` is set to 1. The transfer in progress is unaffected.
- Reset mid-operation: asynchronous. `uart_txd` goes high immediately and the partial byte is abandoned. All outputs return to their reset values.

## Timing

- `rx_done` is accepted at clock edge E0:
  - `busy`=1 and `buf_rdaddress`=0 from E0.
  - The block is in WAIT after E0+1.
  - `buf_q` is captured and `uart_txd` goes 0 (first start bit) at E0+2.
- Read latency: `buf_q` must be valid 2 edges after `buf_rdaddress` changes. This matches a RAM with a registered address and unregistered output.
- Each byte lasts 10·DIV cycles; each word lasts 20·DIV cycles.
- `done`=1 and `busy`=0 at edge E0+2+20·DIV·len. The next `rx_done` can be accepted from the cycle after `done`.
- `uart_txd` is driven from a flop, so it is glitch-free.

## Test plan

- CLK_FREQ=1, BAUD=250000 (DIV=4); word0=0x1234; `rx_len`=1. Required `uart_txd` sequence, 4 cycles per bit:
  - Byte 0x12 from E0+2: 0,0,1,0,0,1,0,0,0,1.
  - Byte 0x34 from E0+42: 0,0,0,1,0,1,1,0,0,1.
  - `done` pulses at E0+82.
- Same setup with `rx_len`=3 and words 0xA55A, 0x00FF, 0x8001:
  - `buf_rdaddress` visits 0,1,2.
  - Six back-to-back bytes A5 5A 00 FF 80 01 with no idle cycles between them.
  - `done` at E0+242.
- `rx_len`=0 with an `rx_done` pulse: `busy` stays 0, `uart_txd` stays 1, and no `done` pulse occurs within 100 cycles.
- `rx_done` pulsed at E0+20 during a transfer:
  - The first frame's output is unchanged and `overrun`=1.
  - The next accepted `rx_done` clears `overrun`.
- `rst_n` pulled low mid-byte at a non-edge time:
  - `uart_txd`=1 and `busy`=0 immediately, and no `done` pulse occurs.
  - After release, a new `rx_done` with `rx_len`=1 transmits correctly.
- W=9 with `rx_len`=1023: the length is clamped to 512, the last address read is 511, and `done` arrives at E0+2+20·4·512.
